// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision definitions for the extreme-value finder:
// field accessors, constants, NaN detection and the control state encoding.
package fp_pkg;

    localparam int FP_W     = 32;
    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;

    localparam logic [FP_W-1:0]     FP_POS_ZERO = 32'h0000_0000;
    localparam logic [FP_W-1:0]     FP_NEG_ZERO = 32'h8000_0000;
    localparam logic [FP_EXP_W-1:0] FP_EXP_ALL1 = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } fsm_state_e;

    function automatic logic fp_sign(input logic [FP_W-1:0] x);
        return x[31];
    endfunction

    function automatic logic [FP_EXP_W-1:0] fp_exp(input logic [FP_W-1:0] x);
        return x[30:23];
    endfunction

    function automatic logic [FP_MAN_W-1:0] fp_man(input logic [FP_W-1:0] x);
        return x[22:0];
    endfunction

    function automatic logic [FP_W-2:0] fp_mag(input logic [FP_W-1:0] x);
        return x[30:0];
    endfunction

    function automatic logic is_nan(input logic [FP_W-1:0] x);
        return (fp_exp(x) == FP_EXP_ALL1) && (fp_man(x) != 23'd0);
    endfunction

endpackage

// File: rtl/fp_key_cmp.sv
// Combinational ordering of two non-NaN floats: a_better is 1 when a is
// strictly larger (max mode) or strictly smaller (min mode) than b.
module fp_key_cmp
    import fp_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    input  logic            mode_min,
    output logic            a_better
);

    logic [FP_W-1:0] key_a_s;
    logic [FP_W-1:0] key_b_s;

    // Map sign-magnitude onto an unsigned total order; -0 folds onto +0 so they tie.
    function automatic logic [FP_W-1:0] order_key(input logic [FP_W-1:0] x);
        logic [FP_W-1:0] c;
        c = (x == FP_NEG_ZERO) ? FP_POS_ZERO : x;
        return fp_sign(c) ? ~c : {1'b1, fp_mag(c)};
    endfunction

    // Strict comparison in the requested direction
    always_comb begin
        key_a_s = order_key(a);
        key_b_s = order_key(b);
        if (mode_min) begin
            a_better = (key_a_s < key_b_s);
        end else begin
            a_better = (key_a_s > key_b_s);
        end
    end

endmodule

// File: rtl/fp_extreme_finder.sv
// Streams N single-precision operands and reports the max or min qualifying
// value with its arrival index; NaNs and sub-eps magnitudes are discarded.
module fp_extreme_finder
    import fp_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N),
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode_min,
    input  logic [FP_W-1:0]  eps,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FP_W-1:0]  in_data,
    output logic             done,
    output logic             found,
    output logic [FP_W-1:0]  result,
    output logic [IDX_W-1:0] result_idx,
    output logic [CNT_W-1:0] ignored_cnt,
    output logic             nan_seen
);

    fsm_state_e       state_q,   state_d;
    logic             mode_q,    mode_d;
    logic [FP_W-2:0]  eps_q,     eps_d;
    logic [FP_W-1:0]  best_q,    best_d;
    logic [IDX_W-1:0] idx_q,     idx_d;
    logic             found_q,   found_d;
    logic [CNT_W-1:0] ign_q,     ign_d;
    logic             nan_q,     nan_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             better_s;
    logic             unused_eps_sign_s;

    assign unused_eps_sign_s = fp_sign(eps);

    fp_key_cmp u_key_cmp (
        .a        (in_data),
        .b        (best_q),
        .mode_min (mode_q),
        .a_better (better_s)
    );

    // Next-state and datapath update for the IDLE -> LOAD -> DONE run sequence
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        eps_d   = eps_q;
        best_d  = best_q;
        idx_d   = idx_q;
        found_d = found_q;
        ign_d   = ign_q;
        nan_d   = nan_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    mode_d  = mode_min;
                    eps_d   = fp_mag(eps);
                    best_d  = FP_POS_ZERO;
                    idx_d   = {IDX_W{1'b0}};
                    found_d = 1'b0;
                    ign_d   = {CNT_W{1'b0}};
                    nan_d   = 1'b0;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (is_nan(in_data)) begin
                        nan_d = 1'b1;
                        ign_d = ign_q + CNT_W'(1);
                    end else if (fp_mag(in_data) < eps_q) begin
                        ign_d = ign_q + CNT_W'(1);
                    end else if (!found_q || better_s) begin
                        // Strict improvement only, so ties keep the earlier index
                        found_d = 1'b1;
                        best_d  = in_data;
                        idx_d   = cnt_q[IDX_W-1:0];
                    end else begin
                        best_d = best_q;
                    end
                    if (cnt_q == CNT_W'(N - 1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    state_d = LOAD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            eps_q   <= {(FP_W-1){1'b0}};
            best_q  <= FP_POS_ZERO;
            idx_q   <= {IDX_W{1'b0}};
            found_q <= 1'b0;
            ign_q   <= {CNT_W{1'b0}};
            nan_q   <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            eps_q   <= eps_d;
            best_q  <= best_d;
            idx_q   <= idx_d;
            found_q <= found_d;
            ign_q   <= ign_d;
            nan_q   <= nan_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready    = (state_q == LOAD);
    assign done        = (state_q == DONE);
    assign found       = found_q;
    assign result      = best_q;
    assign result_idx  = idx_q;
    assign ignored_cnt = ign_q;
    assign nan_seen    = nan_q;

endmodule

// File: tb/tb_fp_extreme_finder.sv
// Self-checking bench for fp_extreme_finder: directed scenarios plus random
// runs scored against a value-level reference model.
module tb_fp_extreme_finder;

    localparam int N     = 4;
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(N + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             mode_min;
    logic [31:0]      eps;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             done;
    logic             found;
    logic [31:0]      result;
    logic [IDX_W-1:0] result_idx;
    logic [CNT_W-1:0] ignored_cnt;
    logic             nan_seen;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] stim [N];

    logic        m_found;
    logic [31:0] m_result;
    int          m_idx;
    int          m_ign;
    logic        m_nan;

    always #5 clk = ~clk;

    fp_extreme_finder #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode_min    (mode_min),
        .eps         (eps),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .done        (done),
        .found       (found),
        .result      (result),
        .result_idx  (result_idx),
        .ignored_cnt (ignored_cnt),
        .nan_seen    (nan_seen)
    );

    // Numeric value of a non-NaN float as a signed integer; same ordering as the reals.
    function automatic longint fval(input logic [31:0] x);
        longint mag;
        mag = longint'(x[30:0]);
        return x[31] ? -mag : mag;
    endfunction

    function automatic logic ref_is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    task automatic model_run(input logic mm, input logic [31:0] e);
        m_found = 1'b0; m_result = 32'h0; m_idx = 0; m_ign = 0; m_nan = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (ref_is_nan(stim[i])) begin
                m_nan = 1'b1; m_ign++;
            end else if (stim[i][30:0] < e[30:0]) begin
                m_ign++;
            end else if (!m_found || (mm ? fval(stim[i]) < fval(m_result)
                                         : fval(stim[i]) > fval(m_result))) begin
                m_found = 1'b1; m_result = stim[i]; m_idx = i;
            end
        end
    endtask

    // Drives one run; returns cycle (start cycle = 0) where done was seen, -1 on timeout.
    task automatic do_run(input logic mm, input logic [31:0] e, input int gap,
                          input int mid_start_cyc, output int done_cyc, output logic cleared);
        int k;
        int cyc;
        k = 0;
        done_cyc = -1;
        @(negedge clk);
        start = 1'b1; mode_min = mm; eps = e;
        @(negedge clk);
        start = 1'b0; mode_min = ~mm; eps = $urandom;
        cyc = 1;
        cleared = (found === 1'b0) && (result === 32'h0) && (result_idx === '0)
                  && (ignored_cnt === '0) && (nan_seen === 1'b0);
        while (cyc < 200) begin
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            start = (cyc == mid_start_cyc);
            in_valid = (k < N) && (gap == 0 || (gap == 1 && cyc[0]) ||
                                   (gap == 2 && $urandom_range(0, 1) == 1));
            in_data = (k < N) ? stim[k] : $urandom;
            if (in_valid && in_ready === 1'b1) k++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode_min = 1'b0; eps = 32'h0; in_valid = 1'b0; in_data = 32'h0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({in_ready, done, found, result, result_idx, ignored_cnt, nan_seen} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got rdy=%b done=%b found=%b res=%h idx=%0d ign=%0d nan=%b, want all 0",
                     in_ready, done, found, result, result_idx, ignored_cnt, nan_seen);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_directed(input string name, input int dc, input int want_dc,
                                  input logic wf, input logic [31:0] wr, input int wi,
                                  input int wg, input logic wn);
        n_checks++;
        if (dc != want_dc) begin
            n_fail++;
            $display("FAIL %s_latency: done at cycle %0d, want %0d", name, dc, want_dc);
        end
        n_checks++;
        if ({found, result, result_idx, ignored_cnt, nan_seen} !==
            {wf, wr, IDX_W'(wi), CNT_W'(wg), wn}) begin
            n_fail++;
            $display("FAIL %s_result: got found=%b res=%h idx=%0d ign=%0d nan=%b, want %b %h %0d %0d %b",
                     name, found, result, result_idx, ignored_cnt, nan_seen, wf, wr, wi, wg, wn);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done_pulse: done=%b rdy=%b one cycle later, want 0 0", name, done, in_ready);
        end
    endtask

    task automatic test_max_min();
        int dc;
        logic cl;
        stim[0] = 32'h3E20_0000; stim[1] = 32'hC060_0000;
        stim[2] = 32'h4100_0000; stim[3] = 32'hBF27_6C8B;
        do_run(1'b0, 32'h3E4C_CCCD, 0, -1, dc, cl);
        check_directed("max", dc, 5, 1'b1, 32'h4100_0000, 2, 1, 1'b0);
        do_run(1'b1, 32'h3E4C_CCCD, 0, -1, dc, cl);
        check_directed("min", dc, 5, 1'b1, 32'hC060_0000, 1, 1, 1'b0);
    endtask

    task automatic test_ties_zeros();
        int dc;
        logic cl;
        stim[0] = 32'h8000_0000; stim[1] = 32'h4100_0000;
        stim[2] = 32'h0000_0000; stim[3] = 32'h4100_0000;
        do_run(1'b0, 32'h0, 0, -1, dc, cl);
        check_directed("ties", dc, 5, 1'b1, 32'h4100_0000, 1, 0, 1'b0);
    endtask

    task automatic test_nan_eps();
        int dc;
        logic cl;
        stim[0] = 32'h7FC0_0000; stim[1] = 32'h3F80_0000;
        stim[2] = 32'hBF80_0000; stim[3] = 32'h0000_0000;
        do_run(1'b0, 32'h4000_0000, 0, -1, dc, cl);
        check_directed("nan_all_below", dc, 5, 1'b0, 32'h0, 0, 4, 1'b1);
    endtask

    task automatic test_gapped_restart();
        int dc;
        logic cl;
        stim[0] = 32'hC120_0000; stim[1] = 32'h3F00_0000;
        stim[2] = 32'h4040_0000; stim[3] = 32'h4040_0000;
        do_run(1'b0, 32'h0, 1, 4, dc, cl);
        check_directed("gapped", dc, 8, 1'b1, 32'h4040_0000, 2, 0, 1'b0);
        in_valid = 1'b1; in_data = 32'h7F7F_FFFF;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({in_ready, found, result, result_idx, ignored_cnt, nan_seen} !==
            {1'b0, 1'b1, 32'h4040_0000, IDX_W'(2), CNT_W'(0), 1'b0}) begin
            n_fail++;
            $display("FAIL hold_in_idle: got rdy=%b found=%b res=%h idx=%0d, want 0 1 40400000 2",
                     in_ready, found, result, result_idx);
        end
        stim[0] = 32'h0000_0001; stim[1] = 32'h0000_0002;
        stim[2] = 32'h0000_0003; stim[3] = 32'h0000_0004;
        do_run(1'b1, 32'h0, 0, -1, dc, cl);
        n_checks++;
        if (cl !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_after_start: outputs not cleared in cycle after start (cleared=%b, want 1)", cl);
        end
        check_directed("after_hold", dc, 5, 1'b1, 32'h0000_0001, 0, 0, 1'b0);
    endtask

    task automatic test_reset_midrun();
        int dc;
        logic cl;
        @(negedge clk);
        start = 1'b1; mode_min = 1'b0; eps = 32'h0;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = 32'h4000_0000;
        @(negedge clk);
        in_data = 32'h7FC0_0001;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (found !== 1'b1 || nan_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL partial_run: found=%b nan=%b after 2 accepts, want 1 1", found, nan_seen);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({in_ready, done, found, result, result_idx, ignored_cnt, nan_seen} !== '0) begin
            n_fail++;
            $display("FAIL reset_midrun: got rdy=%b done=%b found=%b res=%h idx=%0d ign=%0d nan=%b, want all 0",
                     in_ready, done, found, result, result_idx, ignored_cnt, nan_seen);
        end
        stim[0] = 32'hBF80_0000; stim[1] = 32'hC000_0000;
        stim[2] = 32'hC000_0000; stim[3] = 32'hBF00_0000;
        do_run(1'b0, 32'h0, 0, -1, dc, cl);
        check_directed("fresh_after_rst", dc, 5, 1'b1, 32'hBF00_0000, 3, 0, 1'b0);
    endtask

    task automatic test_random();
        int dc;
        logic cl;
        logic mm;
        logic [31:0] e;
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 7))
                    0: stim[i] = {$urandom_range(0, 1) == 1, 8'hFF, 23'($urandom_range(1, 8388607))};
                    1: stim[i] = {$urandom_range(0, 1) == 1, 8'hFF, 23'd0};
                    2: stim[i] = {$urandom_range(0, 1) == 1, 31'd0};
                    3: stim[i] = (i > 0) ? stim[i-1] : 32'h3F80_0000;
                    4: stim[i] = {$urandom_range(0, 1) == 1, 8'($urandom_range(120, 135)), 23'($urandom)};
                    default: stim[i] = $urandom;
                endcase
            end
            case ($urandom_range(0, 3))
                0: e = 32'h0;
                1: e = {$urandom_range(0, 1) == 1, 8'($urandom_range(120, 135)), 23'($urandom)};
                2: e = 32'h3F80_0000;
                default: e = $urandom;
            endcase
            mm = ($urandom_range(0, 1) == 1);
            model_run(mm, e);
            do_run(mm, e, r % 3, (r % 3 == 2) ? 3 : -1, dc, cl);
            n_checks++;
            if (dc < 0 || {found, result, result_idx, ignored_cnt, nan_seen} !==
                {m_found, m_result, IDX_W'(m_idx), CNT_W'(m_ign), m_nan}) begin
                n_fail++;
                $display("FAIL random_%0d: done_cyc=%0d got found=%b res=%h idx=%0d ign=%0d nan=%b, want %b %h %0d %0d %b",
                         r, dc, found, result, result_idx, ignored_cnt, nan_seen,
                         m_found, m_result, m_idx, m_ign, m_nan);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_max_min();
        test_ties_zeros();
        test_nan_eps();
        test_gapped_restart();
        test_reset_midrun();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
